one_wire_master: RTL

Parametrised 1-Wire master that generalises the team's byte transmitter. It generates reset/presence, write slots and read slots on a single open-drain line, with a DATA_W-bit word transferred LSB-first. It sits between a register/command interface and the 1-Wire pad. All timing is derived from CLK_MHZ and per-phase microsecond parameters.

---
 rtl/one_wire_pkg.sv | 24 ++
 rtl/one_wire_sync.sv | 26 ++
 rtl/one_wire_master.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/one_wire_pkg.sv
// Shared definitions for the 1-Wire master: command encodings, FSM state
// enum and the microsecond-to-cycle conversion used for all phase timers.
package one_wire_pkg;

    localparam logic [1:0] OW_RESET       = 2'b00;
    localparam logic [1:0] OW_WRITE       = 2'b01;
    localparam logic [1:0] OW_READ        = 2'b10;
    localparam logic [1:0] OW_RESET_WRITE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_HIGH,
        ST_SLOT_LOW,
        ST_SLOT_HIGH,
        ST_SLOT_REC,
        ST_DONE
    } ow_state_e;

    function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned mhz);
        return us * mhz;
    endfunction

endpackage

// File: rtl/one_wire_sync.sv
// Two-flop synchroniser for the asynchronous 1-Wire bus input.
// Ports: clk, rst (sync, active-high), d_i (raw bus), q_o (synchronised).
// Resets to 1 so an idle (pulled-up) bus is never seen as a presence.
module one_wire_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/one_wire_master.sv
// 1-Wire master: reset/presence, write slots and read slots on an open-drain
// line, DATA_W-bit words LSB-first. Timing derived from CLK_MHZ and *_US.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready/cmd/tx_data command
// side; rx_data, presence, no_dev_err, busy, done status; one_wire_data pad.
//
// state        | meaning
// ST_IDLE      | ready for a command
// ST_RST_LOW   | bus held low for the reset pulse
// ST_RST_HIGH  | bus released, presence sampled
// ST_SLOT_LOW  | slot low phase (write-1/read short, write-0 long)
// ST_SLOT_HIGH | bus released until slot end, read sample taken here
// ST_SLOT_REC  | recovery time between slots
// ST_DONE      | one-cycle completion pulse
module one_wire_master
    import one_wire_pkg::*;
#(
    parameter int unsigned CLK_MHZ   = 100,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned T_RSTL_US = 480,
    parameter int unsigned T_RSTH_US = 480,
    parameter int unsigned T_PDS_US  = 70,
    parameter int unsigned T_SLOT_US = 65,
    parameter int unsigned T_REC_US  = 5,
    parameter int unsigned T_W1L_US  = 6,
    parameter int unsigned T_W0L_US  = 60,
    parameter int unsigned T_RDS_US  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              presence,
    output logic              no_dev_err,
    output logic              busy,
    output logic              done,
    inout  wire               one_wire_data
);

    localparam int unsigned RSTL = us_to_cyc(T_RSTL_US, CLK_MHZ);
    localparam int unsigned RSTH = us_to_cyc(T_RSTH_US, CLK_MHZ);
    localparam int unsigned PDS  = us_to_cyc(T_PDS_US, CLK_MHZ);
    localparam int unsigned SLOT = us_to_cyc(T_SLOT_US, CLK_MHZ);
    localparam int unsigned REC  = us_to_cyc(T_REC_US, CLK_MHZ);
    localparam int unsigned W1L  = us_to_cyc(T_W1L_US, CLK_MHZ);
    localparam int unsigned W0L  = us_to_cyc(T_W0L_US, CLK_MHZ);
    localparam int unsigned RDS  = us_to_cyc(T_RDS_US, CLK_MHZ);

    localparam int unsigned MAX_A   = (RSTL > RSTH) ? RSTL : RSTH;
    localparam int unsigned MAX_B   = (SLOT > W0L) ? SLOT : W0L;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CYC = (MAX_C > REC) ? MAX_C : REC;
    localparam int          CNT_W   = $clog2(MAX_CYC + 1);
    localparam int          BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    ow_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic               pres_q, pres_d;
    logic               nde_q, nde_d;
    logic               drive_low_q, drive_low_d;

    logic               sync_in;
    logic               is_write;
    logic [CNT_W-1:0]   low_len;
    logic [CNT_W-1:0]   slot_pos;
    logic [DATA_W-1:0]  msb_in;

    one_wire_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (one_wire_data),
        .q_o (sync_in)
    );

    assign one_wire_data = drive_low_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= OW_RESET;
            shreg_q     <= '0;
            bit_q       <= '0;
            rx_q        <= '0;
            pres_q      <= 1'b0;
            nde_q       <= 1'b0;
            drive_low_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            shreg_q     <= shreg_d;
            bit_q       <= bit_d;
            rx_q        <= rx_d;
            pres_q      <= pres_d;
            nde_q       <= nde_d;
            drive_low_q <= drive_low_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        cmd_d       = cmd_q;
        shreg_d     = shreg_q;
        bit_d       = bit_q;
        rx_d        = rx_q;
        pres_d      = pres_q;
        nde_d       = nde_q;
        drive_low_d = (state_q == ST_RST_LOW) || (state_q == ST_SLOT_LOW);
        msb_in      = '0;
        msb_in[DATA_W-1] = sync_in;
        is_write    = (cmd_q == OW_WRITE) || (cmd_q == OW_RESET_WRITE);
        low_len     = (is_write && !shreg_q[0]) ? CNT_W'(W0L) : CNT_W'(W1L);
        // The counter restarts in SLOT_HIGH, so slot time = low phase + count.
        slot_pos    = cnt_q + low_len;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cmd_valid && cmd_ready) begin
                    cmd_d   = cmd;
                    shreg_d = tx_data;
                    bit_d   = '0;
                    if ((cmd == OW_RESET) || (cmd == OW_RESET_WRITE)) begin
                        state_d = ST_RST_LOW;
                    end else begin
                        state_d = ST_SLOT_LOW;
                        nde_d   = 1'b0;
                    end
                end
            end
            ST_RST_LOW: begin
                if (cnt_q == CNT_W'(RSTL - 1)) begin
                    state_d = ST_RST_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_RST_HIGH: begin
                if (cnt_q == CNT_W'(PDS - 1)) begin
                    pres_d = !sync_in;
                end
                if (cnt_q == CNT_W'(RSTH - 1)) begin
                    cnt_d = '0;
                    nde_d = !pres_d;
                    if ((cmd_q == OW_RESET_WRITE) && pres_d) begin
                        state_d = ST_SLOT_LOW;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SLOT_LOW: begin
                if (cnt_q == low_len - CNT_W'(1)) begin
                    state_d = ST_SLOT_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_SLOT_HIGH: begin
                if ((cmd_q == OW_READ) && (slot_pos == CNT_W'(RDS - 1))) begin
                    shreg_d = (shreg_q >> 1) | msb_in;
                end
                if (slot_pos == CNT_W'(SLOT - 1)) begin
                    state_d = ST_SLOT_REC;
                    cnt_d   = '0;
                end
            end
            ST_SLOT_REC: begin
                if (cnt_q == CNT_W'(REC - 1)) begin
                    cnt_d = '0;
                    if (is_write) begin
                        shreg_d = shreg_q >> 1;
                    end
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = ST_DONE;
                        if (cmd_q == OW_READ) begin
                            rx_d = shreg_q;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = ST_SLOT_LOW;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign rx_data    = rx_q;
    assign presence   = pres_q;
    assign no_dev_err = nde_q;

endmodule
